// File: rtl/nibble_seq_pkg.sv
// Shared constants for the nibble-serial adder: slice width and FSM encoding.
package nibble_seq_pkg;
    localparam int NW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/adder4c.sv
// 4-bit ripple-carry slice; c3 exposes the carry into bit 3 for overflow detection.
module adder4c (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
    assign c3   = c[3];
endmodule

// File: rtl/nibble_seq_adder.sv
// Nibble-serial adder: one shared 4-bit slice processes one nibble per clock,
// finishing NIB cycles after start is accepted.
module nibble_seq_adder
    import nibble_seq_pkg::*;
#(
    parameter int NIB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NW*NIB-1:0] a,
    input  logic [NW*NIB-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [NW*NIB-1:0] q,
    output logic              cout,
    output logic              ovf
);
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    state_t                   state;
    logic [IW-1:0]            idx;
    logic                     carry;
    logic [NIB-1:0][NW-1:0]   ra, rb, qr;
    logic [NW-1:0]            s;
    logic                     co, c3;

    adder4c u_slice (
        .a    (ra[idx]),
        .b    (rb[idx]),
        .cin  (carry),
        .s    (s),
        .cout (co),
        .c3   (c3)
    );

    assign q = qr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            qr    <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    qr[idx] <= s;
                    carry   <= co;
                    if (idx == LAST) begin
                        // Slice at the top nibble sees bit W-1, so c3/co give signed overflow.
                        idx   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= co;
                        ovf   <= c3 ^ co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_seq_adder.sv
// Scoreboard bench: stimulus pushes expected sums, a monitor pops them on done.
module tb_nibble_seq_adder;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, ovf;
    logic [W-1:0] q;

    typedef struct {
        logic [W-1:0] q;
        logic         co;
        logic         ov;
        int           dc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    nibble_seq_adder #(.NIB(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.q  = full[W-1:0];
        e.co = full[W];
        e.ov = (x[W-1] == y[W-1]) && (e.q[W-1] != x[W-1]);
        e.dc = 0;
        return e;
    endfunction

    // Drives start for one edge; caller ensures the DUT is in IDLE or DONE.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        e    = model(x, y, c);
        e.dc = cyc + 1 + NIB;
        sb.push_back(e);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: busy every cycle, result and latency whenever done is seen.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("busy", busy, (sb.size() != 0) && (cyc < sb[0].dc));
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc, e.dc);
                    chk("q", q, e.q);
                    chk("cout", cout, e.co);
                    chk("ovf", ovf, e.ov);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        chk("reset_state", {q, cout, ovf, busy, done}, '0);
        @(negedge clk) rst = 1'b0;

        issue(16'h5555, 16'hAAAA, 1'b0); wait_idle();
        issue(16'hFFFF, 16'h0001, 1'b0); wait_idle();
        issue(16'h7FFF, 16'h0001, 1'b0); wait_idle();
        issue(16'h8000, 16'h8000, 1'b0); wait_idle();

        // Back-to-back: second start lands on the done cycle of the first.
        issue(16'h1234, 16'h0000, 1'b1);
        repeat (NIB) @(posedge clk);
        issue(16'h0F0F, 16'hF0F0, 1'b0);
        wait_idle();

        // Start and operands wiggled mid-run must be ignored.
        issue(16'h3A5C, 16'h41B7, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h0000; b = 16'h1111;
        wait_idle();

        // Reset between E2 and E3 aborts the run with no done.
        issue(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1 chk("reset_midrun", {q, cout, ovf, busy, done}, '0);
        @(negedge clk) rst = 1'b0;
        repeat (NIB + 2) @(negedge clk);
        issue(16'h0123, 16'h4567, 1'b0); wait_idle();

        for (int i = 0; i < 24; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat (NIB) @(posedge clk);
                issue(W'($urandom), W'($urandom), 1'($urandom));
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
